usb_composite_mux_n: RTL and testbench

Parametrised successor to the two-interface EP1 OUT demultiplexer. It routes framed host command packets to one of NUM_IF class engines (MSC, Raw, and future vendor interfaces). Each engine is selected by a first-word signature table or by a software force. Adds header-word skid buffering, per-interface enable mask, packet framing by last, stall timeout with drain, and per-interface statistics. Sits between ft601_interface EP1 OUT and the class engines; IN endpoints stay direct-wired outside this block.

---
 rtl/usb_mux_pkg.sv | 30 +++
 rtl/usb_sig_classifier.sv | 37 +++
 rtl/usb_composite_mux_n.sv | 220 ++++++++++++++++++++++
 tb/tb_usb_composite_mux_n.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_mux_pkg
//  Description : Shared types and constants for the EP1 OUT composite
//                command demultiplexer (FSM encoding, signatures, helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_mux_pkg;

    localparam int MUX_STATE_W = 3;

    typedef enum logic [MUX_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_FWD_HDR   = 3'd1,
        ST_FWD_BODY  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DROP      = 3'd4
    } mux_state_t;

    // Well-known first-word signatures of the class engines
    localparam logic [31:0] CBW_SIG = 32'h43425355;
    localparam logic [31:0] RAW_SIG = 32'h46525751;

    // Width of an interface index; never narrower than one bit
    function automatic int if_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_sig_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : usb_sig_classifier
//  Description : Combinational match of a header word against the signature
//                table; the lowest matching interface index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_sig_classifier
    import usb_mux_pkg::*;
#(
    parameter int                       NUM_IF    = 4,
    parameter int                       DATA_W    = 32,
    parameter logic [NUM_IF*DATA_W-1:0] SIG_TABLE = '0
) (
    input  logic [DATA_W-1:0]          word,
    output logic                       hit,
    output logic [$clog2(NUM_IF)-1:0]  index
);

    localparam int IF_W = $clog2(NUM_IF);

    // Scan from the top down so the lowest matching slot overrides the rest;
    // an all-zero slot means "no signature" and can never match.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = NUM_IF - 1; i >= 0; i--) begin
            if ((SIG_TABLE[i*DATA_W +: DATA_W] != '0) &&
                (SIG_TABLE[i*DATA_W +: DATA_W] == word)) begin
                hit   = 1'b1;
                index = i[IF_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_composite_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : usb_composite_mux_n
//  Description : Routes framed EP1 OUT command packets to one of NUM_IF
//                class engines chosen by first-word signature or software
//                force, with header skid register, enable mask, stall
//                timeout/drain and per-interface statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_composite_mux_n
    import usb_mux_pkg::*;
#(
    parameter int                       NUM_IF         = 4,
    parameter int                       DATA_W         = 32,
    parameter logic [NUM_IF*DATA_W-1:0] SIG_TABLE      = {32'h0, 32'h0, RAW_SIG, CBW_SIG},
    parameter int                       DEFAULT_IF     = 0,
    parameter int                       TIMEOUT_CYCLES = 65535,
    parameter int                       CNT_W          = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           ep_rx_data,
    input  logic                        ep_rx_valid,
    input  logic                        ep_rx_last,
    output logic                        ep_rx_ready,
    output logic [NUM_IF*DATA_W-1:0]    if_cmd_data,
    output logic [NUM_IF-1:0]           if_cmd_valid,
    output logic [NUM_IF-1:0]           if_cmd_last,
    input  logic [NUM_IF-1:0]           if_cmd_ready,
    input  logic [NUM_IF-1:0]           if_busy,
    input  logic [NUM_IF-1:0]           if_enable,
    input  logic                        sw_force_en,
    input  logic [$clog2(NUM_IF)-1:0]   sw_force_if,
    output logic [$clog2(NUM_IF)-1:0]   active_if,
    output logic                        locked,
    output logic [2:0]                  mux_state,
    output logic [NUM_IF*CNT_W-1:0]     pkt_count,
    output logic [CNT_W-1:0]            drop_count,
    output logic [CNT_W-1:0]            timeout_count
);

    localparam int               IF_W        = $clog2(NUM_IF);
    localparam logic [IF_W:0]    NUM_EXT     = (IF_W+1)'(NUM_IF);
    localparam logic [IF_W:0]    DEFAULT_EXT = (DEFAULT_IF < NUM_IF) ? (IF_W+1)'(DEFAULT_IF) : NUM_EXT;
    localparam bit               TO_EN       = (TIMEOUT_CYCLES > 0);
    localparam int               TO_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    mux_state_t                      state;
    logic [DATA_W-1:0]               hdr_reg;
    logic                            hdr_last;
    logic [IF_W-1:0]                 target;
    logic                            dropped;
    logic [TO_W-1:0]                 stall_cnt;
    logic [NUM_IF-1:0][CNT_W-1:0]    pkt_cnt;
    logic [NUM_IF-1:0][DATA_W-1:0]   cmd_data;

    logic                            sig_hit;
    logic [IF_W-1:0]                 sig_idx;
    logic [IF_W:0]                   req_if;
    logic                            req_ok;
    logic                            ep_hs;
    logic                            timeout_now;
    logic [TO_W-1:0]                 stall_next;

    usb_sig_classifier #(
        .NUM_IF    (NUM_IF),
        .DATA_W    (DATA_W),
        .SIG_TABLE (SIG_TABLE)
    ) u_classifier (
        .word  (ep_rx_data),
        .hit   (sig_hit),
        .index (sig_idx)
    );

    // Resolve the requested interface; one extra bit lets an out-of-range
    // default or force be recognised instead of aliasing onto a real port.
    always_comb begin
        if (sw_force_en)
            req_if = {1'b0, sw_force_if};
        else if (sig_hit)
            req_if = {1'b0, sig_idx};
        else
            req_if = DEFAULT_EXT;
    end

    assign req_ok      = (req_if < NUM_EXT) && if_enable[req_if[IF_W-1:0]];
    assign ep_hs       = ep_rx_valid && ep_rx_ready;
    assign timeout_now = TO_EN && (stall_cnt == TO_LAST);
    assign stall_next  = TO_EN ? stall_cnt + TO_W'(1) : '0;

    assign mux_state   = state;
    assign pkt_count   = pkt_cnt;
    assign if_cmd_data = cmd_data;

    // Steering of header / body words onto the latched target channel
    always_comb begin
        cmd_data     = '0;
        if_cmd_valid = '0;
        if_cmd_last  = '0;
        ep_rx_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Reset is asynchronous, so hold off acceptance while it is asserted
                ep_rx_ready = !rst;
            end
            ST_FWD_HDR: begin
                cmd_data[target]     = hdr_reg;
                if_cmd_valid[target] = 1'b1;
                if_cmd_last[target]  = hdr_last;
            end
            ST_FWD_BODY: begin
                cmd_data[target]     = ep_rx_data;
                if_cmd_valid[target] = ep_rx_valid;
                if_cmd_last[target]  = ep_rx_last;
                ep_rx_ready          = if_cmd_ready[target];
            end
            ST_DROP: begin
                ep_rx_ready = 1'b1;
            end
            default: begin
                ep_rx_ready = 1'b0;
            end
        endcase
    end

    // Packet FSM with capture, stall supervision and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            hdr_reg       <= '0;
            hdr_last      <= 1'b0;
            target        <= '0;
            dropped       <= 1'b0;
            stall_cnt     <= '0;
            active_if     <= '0;
            locked        <= 1'b0;
            pkt_cnt       <= '0;
            drop_count    <= '0;
            timeout_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stall_cnt <= '0;
                    if (ep_hs) begin
                        hdr_reg  <= ep_rx_data;
                        hdr_last <= ep_rx_last;
                        target   <= req_if[IF_W-1:0];
                        if (req_ok) begin
                            state                     <= ST_FWD_HDR;
                            dropped                   <= 1'b0;
                            locked                    <= 1'b1;
                            active_if                 <= req_if[IF_W-1:0];
                            pkt_cnt[req_if[IF_W-1:0]] <= pkt_cnt[req_if[IF_W-1:0]] + CNT_W'(1);
                        end else begin
                            state      <= ep_rx_last ? ST_WAIT_DONE : ST_DROP;
                            dropped    <= 1'b1;
                            drop_count <= drop_count + CNT_W'(1);
                        end
                    end
                end
                ST_FWD_HDR: begin
                    if (if_cmd_ready[target]) begin
                        state     <= hdr_last ? ST_WAIT_DONE : ST_FWD_BODY;
                        stall_cnt <= '0;
                    end else if (timeout_now) begin
                        // A one-word packet has nothing left on the bus to flush
                        state         <= hdr_last ? ST_IDLE : ST_DROP;
                        dropped       <= 1'b1;
                        locked        <= 1'b0;
                        stall_cnt     <= '0;
                        timeout_count <= timeout_count + CNT_W'(1);
                    end else begin
                        stall_cnt <= stall_next;
                    end
                end
                ST_FWD_BODY: begin
                    if (ep_hs) begin
                        stall_cnt <= '0;
                        if (ep_rx_last)
                            state <= ST_WAIT_DONE;
                    end else if (timeout_now) begin
                        state         <= ST_DROP;
                        dropped       <= 1'b1;
                        locked        <= 1'b0;
                        stall_cnt     <= '0;
                        timeout_count <= timeout_count + CNT_W'(1);
                    end else begin
                        stall_cnt <= stall_next;
                    end
                end
                ST_WAIT_DONE: begin
                    if (dropped || !if_busy[target]) begin
                        state     <= ST_IDLE;
                        locked    <= 1'b0;
                        stall_cnt <= '0;
                    end else if (timeout_now) begin
                        state         <= ST_IDLE;
                        locked        <= 1'b0;
                        stall_cnt     <= '0;
                        timeout_count <= timeout_count + CNT_W'(1);
                    end else begin
                        stall_cnt <= stall_next;
                    end
                end
                ST_DROP: begin
                    stall_cnt <= '0;
                    if (ep_hs && ep_rx_last)
                        state <= ST_WAIT_DONE;
                end
                default: begin
                    state  <= ST_IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_composite_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_composite_mux_n
//  Description : Directed self-checking bench for usb_composite_mux_n with a
//                packet-level routing model and per-channel expected queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_composite_mux_n;

    localparam int NIF = 4;
    localparam int DW  = 32;
    localparam int CW  = 32;
    localparam int BIG = 1000000;

    logic               clk;
    logic               rst;
    logic [DW-1:0]      ep_rx_data;
    logic               ep_rx_valid;
    logic               ep_rx_last;
    logic               ep_rx_ready;
    logic [NIF*DW-1:0]  if_cmd_data;
    logic [NIF-1:0]     if_cmd_valid;
    logic [NIF-1:0]     if_cmd_last;
    logic [NIF-1:0]     if_cmd_ready;
    logic [NIF-1:0]     if_busy;
    logic [NIF-1:0]     if_enable;
    logic               sw_force_en;
    logic [1:0]         sw_force_if;
    logic [1:0]         active_if;
    logic               locked;
    logic [2:0]         mux_state;
    logic [NIF*CW-1:0]  pkt_count;
    logic [CW-1:0]      drop_count;
    logic [CW-1:0]      timeout_count;

    usb_composite_mux_n #(
        .NUM_IF         (NIF),
        .DATA_W         (DW),
        .SIG_TABLE      ({32'h0, 32'h0, 32'h46525751, 32'h43425355}),
        .DEFAULT_IF     (0),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ep_rx_data    (ep_rx_data),
        .ep_rx_valid   (ep_rx_valid),
        .ep_rx_last    (ep_rx_last),
        .ep_rx_ready   (ep_rx_ready),
        .if_cmd_data   (if_cmd_data),
        .if_cmd_valid  (if_cmd_valid),
        .if_cmd_last   (if_cmd_last),
        .if_cmd_ready  (if_cmd_ready),
        .if_busy       (if_busy),
        .if_enable     (if_enable),
        .sw_force_en   (sw_force_en),
        .sw_force_if   (sw_force_if),
        .active_if     (active_if),
        .locked        (locked),
        .mux_state     (mux_state),
        .pkt_count     (pkt_count),
        .drop_count    (drop_count),
        .timeout_count (timeout_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Model state: signatures, expected deliveries and counters
    logic [31:0] sig_tab [4];
    logic [32:0] exp_q   [4][$];
    int          exp_pkt [4];
    int          exp_drop;
    int          exp_to;
    int          got     [4];
    int          limit   [4];
    int          stall_left [4];
    logic [31:0] tx_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Routing rule: force, else lowest non-zero signature match, else default 0;
    // returns -1 when the packet must be discarded.
    function automatic int model_route(input logic [31:0] w, input bit fen,
                                       input logic [1:0] fif, input logic [3:0] en);
        int t;
        bit found;
        t     = 0;
        found = 1'b0;
        if (fen) begin
            t = int'(fif);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!found && sig_tab[i] != 32'h0 && sig_tab[i] == w) begin
                    t     = i;
                    found = 1'b1;
                end
            end
        end
        return (t < 4 && en[t]) ? t : -1;
    endfunction

    // Downstream engines: ready unless stalled or their accept budget is spent
    initial begin : sink
        if_cmd_ready = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if_cmd_ready[i] = (stall_left[i] == 0) && (got[i] < limit[i]);
                if (stall_left[i] > 0) stall_left[i]--;
            end
        end
    end

    // Per-cycle compare just before each active edge
    initial begin : compare
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                check("reset_outputs", {63'h0, |{ep_rx_ready, if_cmd_data, if_cmd_valid, if_cmd_last,
                      active_if, locked, mux_state, pkt_count, drop_count, timeout_count}}, 64'h0);
            end else begin
                check("valid_onehot", {63'h0, ($countones(if_cmd_valid) <= 1)}, 64'h1);
                for (int i = 0; i < 4; i++) begin
                    if (if_cmd_valid[i] && !if_cmd_ready[i])
                        check("backpressure_ep_ready", {63'h0, ep_rx_ready}, 64'h0);
                    if (if_cmd_valid[i] && if_cmd_ready[i]) begin
                        if (exp_q[i].size() == 0) begin
                            check("unexpected_word", {31'h0, if_cmd_last[i], if_cmd_data[i*DW +: DW]}, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            e = exp_q[i].pop_front();
                            check($sformatf("ch%0d_word", i), {31'h0, if_cmd_last[i], if_cmd_data[i*DW +: DW]}, {31'h0, e});
                        end
                        got[i]++;
                    end
                end
            end
        end
    end

    // Present tx_q as one packet; reports the longest run of not-ready cycles
    task automatic send(output int max_gap);
        int idx;
        int gap;
        int budget;
        idx = 0; gap = 0; budget = 0; max_gap = 0;
        while (idx < tx_q.size()) begin
            @(negedge clk);
            ep_rx_valid = 1'b1;
            ep_rx_data  = tx_q[idx];
            ep_rx_last  = (idx == tx_q.size() - 1);
            #1;
            if (ep_rx_ready) begin
                idx++;
                gap = 0;
            end else begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
            budget++;
            if (budget > 400) begin
                check("send_budget", 64'(idx), 64'(tx_q.size()));
                break;
            end
        end
        @(negedge clk);
        ep_rx_valid = 1'b0;
        ep_rx_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 64) begin
            @(negedge clk);
            #1;
            if (mux_state == 3'd0) break;
            n++;
        end
        check("return_to_idle", {61'h0, mux_state}, 64'h0);
    endtask

    task automatic run_pkt(input logic [31:0] hdr, input int n, input int lim,
                           input bit fen, input logic [1:0] fif, output int gap);
        int t;
        sw_force_en = fen;
        sw_force_if = fif;
        tx_q.delete();
        for (int k = 0; k < n; k++)
            tx_q.push_back((k == 0) ? hdr : hdr + 32'(k) * 32'h00010001);
        t = model_route(hdr, fen, fif, if_enable);
        if (t < 0) begin
            exp_drop++;
        end else begin
            exp_pkt[t]++;
            limit[t] = got[t] + lim;
            for (int k = 0; k < n && k < lim; k++)
                exp_q[t].push_back({(k == n - 1), tx_q[k]});
            if (lim < n) exp_to++;
        end
        send(gap);
        sw_force_en = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_pkt_count%0d", tag, i), 64'(pkt_count[i*CW +: CW]), 64'(exp_pkt[i]));
            check($sformatf("%s_queue%0d_drained", tag, i), 64'(exp_q[i].size()), 64'h0);
        end
        check({tag, "_drop_count"}, 64'(drop_count), 64'(exp_drop));
        check({tag, "_timeout_count"}, 64'(timeout_count), 64'(exp_to));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench stalled");
    end

    initial begin : main
        int gap;
        int hs;
        int cyc;
        sig_tab     = '{32'h43425355, 32'h46525751, 32'h0, 32'h0};
        rst         = 1'b1;
        ep_rx_data  = '0;
        ep_rx_valid = 1'b0;
        ep_rx_last  = 1'b0;
        if_busy     = '0;
        if_enable   = 4'hF;
        sw_force_en = 1'b0;
        sw_force_if = 2'd0;
        exp_drop    = 0;
        exp_to      = 0;
        for (int i = 0; i < 4; i++) begin
            exp_pkt[i] = 0; got[i] = 0; limit[i] = BIG; stall_left[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_ready", {63'h0, ep_rx_ready}, 64'h1);
        check("idle_state", {61'h0, mux_state}, 64'h0);

        // 4-word MSC packet, engine busy after the last word
        if_busy = 4'b0001;
        run_pkt(32'h43425355, 4, BIG, 1'b0, 2'd0, gap);
        check("t1_max_gap", 64'(gap), 64'd1);
        #1;
        check("t1_wait_state", {61'h0, mux_state}, 64'd3);
        check("t1_locked", {63'h0, locked}, 64'h1);
        check("t1_active_if", {62'h0, active_if}, 64'd0);
        check("t1_pkt0_literal", 64'(pkt_count[31:0]), 64'd1);
        if_busy = 4'b0000;
        wait_idle();
        check("t1_unlocked", {63'h0, locked}, 64'h0);
        check_counters("t1");

        // Raw packet with channel 1 back-pressured for 10 cycles
        stall_left[1] = 10;
        run_pkt(32'h46525751, 5, BIG, 1'b0, 2'd0, gap);
        check("t2_max_gap", 64'(gap), 64'd10);
        wait_idle();
        check_counters("t2");

        // Unknown header falls to disabled default interface: drained
        if_enable = 4'b1110;
        run_pkt(32'hDEADBEEF, 3, BIG, 1'b0, 2'd0, gap);
        check("t3_ready_throughout", 64'(gap), 64'd0);
        wait_idle();
        check("t3_drop_literal", 64'(drop_count), 64'd1);
        check_counters("t3");
        if_enable = 4'hF;

        // Software force overrides a matching signature
        run_pkt(32'h43425355, 3, BIG, 1'b1, 2'd2, gap);
        wait_idle();
        check("t4_pkt2_literal", 64'(pkt_count[95:64]), 64'd1);
        check("t4_pkt0_literal", 64'(pkt_count[31:0]), 64'd1);
        check_counters("t4");

        // One-word packet
        run_pkt(32'h46525751, 1, BIG, 1'b0, 2'd0, gap);
        wait_idle();
        check("t5_pkt1_literal", 64'(pkt_count[63:32]), 64'd2);
        check_counters("t5");

        // Forced onto a disabled interface: single word discarded
        if_enable = 4'b0111;
        run_pkt(32'h43425355, 1, BIG, 1'b1, 2'd3, gap);
        wait_idle();
        check("t6_drop_literal", 64'(drop_count), 64'd2);
        check_counters("t6");
        if_enable = 4'hF;

        // Channel 0 stops after 3 words: 16-cycle timeout, remainder drained
        run_pkt(32'h43425355, 8, 3, 1'b0, 2'd0, gap);
        check("t7_stall_cycles", 64'(gap), 64'd16);
        wait_idle();
        check("t7_timeout_literal", 64'(timeout_count), 64'd1);
        check_counters("t7");

        // Reset while forwarding a body to channel 3
        sw_force_en = 1'b1;
        sw_force_if = 2'd3;
        exp_pkt[3]++;
        for (int k = 0; k < 3; k++)
            exp_q[3].push_back({1'b0, 32'hA5A50000 + 32'(k)});
        hs = 0; cyc = 0;
        while (hs < 3 && cyc < 50) begin
            @(negedge clk);
            ep_rx_valid = 1'b1;
            ep_rx_last  = 1'b0;
            ep_rx_data  = 32'hA5A50000 + 32'(hs);
            #1;
            if (ep_rx_ready) hs++;
            cyc++;
        end
        check("t8_handshakes", 64'(hs), 64'd3);
        @(negedge clk);
        ep_rx_data = 32'hA5A50003;
        #1;
        check("t8_in_body", {61'h0, mux_state}, 64'd2);
        check("t8_locked", {63'h0, locked}, 64'h1);
        check("t8_queue3_delivered", 64'(exp_q[3].size()), 64'h0);
        rst = 1'b1;
        #2;
        check("t8_rst_ctrl", {56'h0, locked, mux_state, active_if, ep_rx_ready, |if_cmd_valid}, 64'h0);
        check("t8_rst_pkt3", 64'(pkt_count[127:96]), 64'h0);
        @(negedge clk);
        ep_rx_valid = 1'b0;
        sw_force_en = 1'b0;
        rst         = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_pkt[i] = 0;
            exp_q[i].delete();
        end
        exp_drop = 0;
        exp_to   = 0;
        check_counters("t8_after_reset");
        run_pkt(32'h43425355, 2, BIG, 1'b0, 2'd0, gap);
        wait_idle();
        check("t8_pkt0_literal", 64'(pkt_count[31:0]), 64'd1);
        check_counters("t8");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
